// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and address-width helper for the stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_e;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-entry shift vectors tracking in-flight writes until writeback.
module reg_scoreboard #(
    parameter int NUM_ENTRIES = 9,
    parameter int WB_LAT      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ENTRIES-1:0] set_i,
    output logic [NUM_ENTRIES-1:0] pend_hi_o,
    output logic [NUM_ENTRIES-1:0] pend_any_o
);

    logic [NUM_ENTRIES-1:0][WB_LAT-1:0] vec_q, vec_d;

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ent
        // a new write lands in the top bit; older records keep draining toward bit 0
        assign vec_d[e] = (vec_q[e] >> 1) | (WB_LAT'(set_i[e]) << (WB_LAT - 1));
        assign pend_any_o[e] = |vec_q[e];
        if (WB_LAT > 1) begin : g_hi
            assign pend_hi_o[e] = |vec_q[e][WB_LAT-1:1];
        end else begin : g_lo
            assign pend_hi_o[e] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vec_q <= '0;
        else     vec_q <= vec_d;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decides issue/stall/bubble for stage 2 from the write scoreboard
// and the branch hold/flush FSM.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int NUM_SRC    = 2,
    parameter int WB_LAT     = 3,
    parameter int BYPASS     = 1,
    parameter int BR_PENALTY = 2,
    parameter int ZERO_REG   = 0,
    localparam int AW        = addr_w(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NUM_SRC-1:0]    id_src_vld,
    input  logic [NUM_SRC*AW-1:0] id_src_addr,
    input  logic                  id_dst_vld,
    input  logic [AW-1:0]         id_dst_addr,
    input  logic                  id_sp_rd,
    input  logic                  id_sp_wr,
    input  logic                  id_br,
    input  logic                  id_cbr,
    input  logic                  br_resolve,
    input  logic                  br_taken,
    input  logic                  ext_hold,
    output logic                  issue,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush,
    output logic [NUM_REGS:0]     busy_map
);

    localparam int NE = NUM_REGS + 1;
    localparam int CW = addr_w(BR_PENALTY);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NE-1:0]   set, pend_hi, pend_any, pend;
    logic [NUM_REGS-1:0] pend_r;
    logic            hazard, idle, dst_rec;

    reg_scoreboard #(.NUM_ENTRIES(NE), .WB_LAT(WB_LAT)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (set),
        .pend_hi_o (pend_hi),
        .pend_any_o(pend_any)
    );

    // with forwarding, the writeback-cycle bit is already usable
    assign pend     = (BYPASS != 0) ? pend_hi : pend_any;
    assign pend_r   = pend[NUM_REGS-1:0];
    assign busy_map = pend_any;

    always_comb begin
        hazard = id_sp_rd & pend[NUM_REGS];
        for (int s = 0; s < NUM_SRC; s++)
            hazard = hazard | (id_src_vld[s] & pend_r[id_src_addr[s*AW +: AW]]);
    end

    assign idle    = state_q == IDLE;
    assign issue   = !rst & id_valid & idle & !hazard & !ext_hold;
    assign stall   = !rst & (hazard | ext_hold | !idle);
    assign bubble  = !rst & !issue;
    assign flush   = state_q == FLUSH;
    assign dst_rec = issue & id_dst_vld & !((ZERO_REG != 0) && (id_dst_addr == '0));
    assign set     = (NE'(dst_rec) << id_dst_addr) | (NE'(issue & id_sp_wr) << NUM_REGS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (issue & id_cbr) begin
                    state_d = RESOLVE;
                end else if (issue & id_br) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(BR_PENALTY - 1);
                end
            end
            RESOLVE: begin
                if (br_resolve) begin
                    state_d = br_taken ? FLUSH : IDLE;
                    cnt_d   = CW'(BR_PENALTY - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: two configurations driven with shared random stimulus against
// a ready-countdown reference model.
module tb_hazard_stall_ctrl;

    localparam int WBL[2] = '{3, 4};
    localparam int BYP[2] = '{1, 0};
    localparam int BRP[2] = '{2, 3};
    localparam int ZR[2]  = '{0, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       valid, dst_vld, sp_rd, sp_wr, br, cbr, resolve, taken, hold;
    logic [1:0] src_vld;
    logic [5:0] src_addr;
    logic [2:0] dst;
    logic [1:0] iss, stl, bub, fls;
    logic [8:0] bm [2];

    int n_tests = 0;
    int n_fail  = 0;

    int rem [2][9];
    bit bw  [2];
    int fl  [2];

    always #5 clk = ~clk;

    hazard_stall_ctrl dut0 (
        .clk(clk), .rst(rst), .id_valid(valid), .id_src_vld(src_vld), .id_src_addr(src_addr),
        .id_dst_vld(dst_vld), .id_dst_addr(dst), .id_sp_rd(sp_rd), .id_sp_wr(sp_wr),
        .id_br(br), .id_cbr(cbr), .br_resolve(resolve), .br_taken(taken), .ext_hold(hold),
        .issue(iss[0]), .stall(stl[0]), .bubble(bub[0]), .flush(fls[0]), .busy_map(bm[0])
    );

    hazard_stall_ctrl #(.WB_LAT(4), .BYPASS(0), .BR_PENALTY(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(valid), .id_src_vld(src_vld), .id_src_addr(src_addr),
        .id_dst_vld(dst_vld), .id_dst_addr(dst), .id_sp_rd(sp_rd), .id_sp_wr(sp_wr),
        .id_br(br), .id_cbr(cbr), .br_resolve(resolve), .br_taken(taken), .ext_hold(hold),
        .issue(iss[1]), .stall(stl[1]), .bubble(bub[1]), .flush(fls[1]), .busy_map(bm[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        valid = 0; src_vld = 0; src_addr = 0; dst_vld = 0; dst = 0;
        sp_rd = 0; sp_wr = 0; br = 0; cbr = 0; resolve = 0; taken = 0; hold = 0;
    endtask

    // rem = cycles a register stays busy; hazard while more than the forwardable last cycle remains
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            int         th;
            bit         haz, idl, ei;
            logic [8:0] ebm;
            if (rst) begin
                for (int i = 0; i < 9; i++) rem[k][i] = 0;
                bw[k] = 0;
                fl[k] = 0;
            end
            th  = BYP[k];
            haz = sp_rd && rem[k][8] > th;
            for (int s = 0; s < 2; s++) begin
                int a;
                a = int'(src_addr[s*3 +: 3]);
                if (src_vld[s] && rem[k][a] > th) haz = 1;
            end
            idl = !bw[k] && fl[k] == 0;
            ei  = !rst && valid && idl && !haz && !hold;
            for (int i = 0; i < 9; i++) ebm[i] = rem[k][i] > 0;
            check($sformatf("issue%0d", k), 32'(iss[k]), 32'(ei));
            check($sformatf("stall%0d", k), 32'(stl[k]), 32'(!rst && (haz || hold || !idl)));
            check($sformatf("bubble%0d", k), 32'(bub[k]), 32'(!rst && !ei));
            check($sformatf("flush%0d", k), 32'(fls[k]), 32'(fl[k] > 0));
            check($sformatf("busy_map%0d", k), 32'(bm[k]), 32'(ebm));
            if (!rst) begin
                for (int i = 0; i < 9; i++) if (rem[k][i] > 0) rem[k][i]--;
                if (ei && dst_vld && !(ZR[k] != 0 && dst == 0)) rem[k][dst] = WBL[k];
                if (ei && sp_wr) rem[k][8] = WBL[k];
                if (fl[k] > 0) fl[k]--;
                else if (bw[k]) begin
                    if (resolve) begin
                        bw[k] = 0;
                        if (taken) fl[k] = BRP[k];
                    end
                end else if (ei) begin
                    if (cbr) bw[k] = 1;
                    else if (br) fl[k] = BRP[k];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_in();
        bit narrow;
        narrow   = $urandom_range(0, 1) == 1;
        valid    = $urandom_range(0, 3) != 0;
        src_vld  = valid ? 2'($urandom) : 2'b00;
        src_addr = narrow ? {1'b0, 2'($urandom), 1'b0, 2'($urandom)} : 6'($urandom);
        dst_vld  = $urandom_range(0, 1) == 1;
        dst      = narrow ? {1'b0, 2'($urandom)} : 3'($urandom);
        sp_rd    = valid && $urandom_range(0, 3) == 0;
        sp_wr    = $urandom_range(0, 5) == 0;
        cbr      = $urandom_range(0, 9) == 0;
        br       = $urandom_range(0, 9) == 0;
        resolve  = $urandom_range(0, 2) == 0;
        taken    = $urandom_range(0, 1) == 1;
        hold     = $urandom_range(0, 7) == 0;
    endtask

    initial begin
        clear_in();
        rst = 1;
        @(negedge clk);
        step();
        rst = 0;
        // RAW on R3 back to back, then drain
        valid = 1; dst_vld = 1; dst = 3;
        step();
        dst_vld = 0; src_vld = 2'b01; src_addr = 6'd3;
        for (int i = 0; i < 5; i++) step();
        // SP write then SP read
        clear_in(); valid = 1; sp_wr = 1;
        step();
        sp_wr = 0; sp_rd = 1;
        for (int i = 0; i < 5; i++) step();
        // unconditional branch
        clear_in(); valid = 1; br = 1;
        for (int i = 0; i < 5; i++) step();
        // conditional branch writing R2, reset while resolving, then R2 read
        clear_in(); valid = 1; cbr = 1; dst_vld = 1; dst = 2;
        step();
        clear_in();
        step();
        rst = 1;
        step();
        rst = 0; valid = 1; src_vld = 2'b01; src_addr = 6'd2;
        step();
        // taken conditional branch resolved after 3 cycles
        clear_in(); valid = 1; cbr = 1;
        step();
        for (int i = 0; i < 2; i++) step();
        resolve = 1; taken = 1;
        step();
        clear_in(); valid = 1;
        for (int i = 0; i < 5; i++) step();
        for (int c = 0; c < 3000; c++) begin
            rand_in();
            rst = $urandom_range(0, 63) == 0;
            step();
        end
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
